// File: rtl/fmadd_pkg.sv
// Shared definitions for the FMAdd significand path: CLA group geometry and
// the per-group stage-1 result record used by eac_carry_resolve_pipe.
package fmadd_pkg;

    localparam int CLA_GRP_WIDTH = 25;
    localparam int N_CLA_GROUPS  = 2;
    localparam int ADDER_WIDTH   = CLA_GRP_WIDTH * N_CLA_GROUPS;

    // One carry-lookahead group after stage 1: both candidate sums plus the
    // group-generate / group-propagate flags that stage 2 uses to pick one.
    typedef struct packed {
        logic [CLA_GRP_WIDTH-1:0] sum;     // group sum with carry-in 0
        logic [CLA_GRP_WIDTH-1:0] sum_p1;  // group sum with carry-in 1
        logic                     gg;      // carry-out with carry-in 0
        logic                     gp;      // carry-in 1 ripples to carry-out
    } grp_res_t;

endpackage

// File: rtl/eac_carry_chain.sv
// Combinational end-around carry resolution across CLA groups.
// c_o[0] is the wrap term (carry-out of the whole adder with carry-in 0);
// c_o[g] for g > 0 is the carry into group g given that wrap carry.
module eac_carry_chain
    import fmadd_pkg::*;
#(
    parameter int N_GROUPS = N_CLA_GROUPS
) (
    input  logic [N_GROUPS-1:0] gg_i,
    input  logic [N_GROUPS-1:0] gp_i,
    output logic [N_GROUPS-1:0] c_o
);

    logic [N_GROUPS-1:0] c;

    // Wrap carry first, then ripple it through the group generate/propagate terms.
    always_comb begin : carry_resolve
        logic wrap;
        logic term;
        // NOTE: every variable written here gets a value before any branch or
        // loop can skip it; a path that leaves one unassigned infers a latch.
        wrap = 1'b0;
        term = 1'b0;
        c    = '0;
        // A group's generate reaches the top only if every higher group propagates.
        // When all groups propagate there is no generate anywhere, so the wrap
        // term stays 0 and -0 is not incremented a second time.
        for (int j = 0; j < N_GROUPS; j++) begin
            term = gg_i[j];
            for (int k = j + 1; k < N_GROUPS; k++) begin
                term = term & gp_i[k];
            end
            wrap = wrap | term;
        end
        c[0] = wrap;
        for (int g = 1; g < N_GROUPS; g++) begin
            c[g] = gg_i[g-1] | (gp_i[g-1] & c[g-1]);
        end
    end

    assign c_o = c;

endmodule

// File: rtl/eac_carry_resolve_pipe.sv
// Two-stage pipelined end-around-carry (one's-complement) adder.
// Stage 1: per-group sum, sum+1, group generate and group propagate.
// Stage 2: end-around carry resolution and per-group select into the output regs.
// Optional feature macro: EAC_NEG_ZERO_FIX_EN (rewrite an all-ones result to +0).
// The stage-1 record type comes from fmadd_pkg, so overriding the group
// parameters also requires the matching package values.
module eac_carry_resolve_pipe
    import fmadd_pkg::grp_res_t;
#(
    parameter int  CLA_GRP_WIDTH = fmadd_pkg::CLA_GRP_WIDTH,
    parameter int  N_CLA_GROUPS  = fmadd_pkg::N_CLA_GROUPS,
    localparam int ADDER_WIDTH   = CLA_GRP_WIDTH * N_CLA_GROUPS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDER_WIDTH-1:0] a,
    input  logic [ADDER_WIDTH-1:0] b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDER_WIDTH-1:0] sum,
    output logic                   sign,
    output logic                   is_zero
);

    localparam int GW = CLA_GRP_WIDTH;

    // Handshake / stall control
    logic s1_valid_q;
    logic out_valid_q;
    logic s2_adv;
    logic s1_adv;

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q  || s2_adv;
    assign in_ready = s1_adv;

    // Stage 1: per-group candidate sums and lookahead flags
    grp_res_t grp_d [N_CLA_GROUPS];
    grp_res_t grp_q [N_CLA_GROUPS];

    for (genvar g = 0; g < N_CLA_GROUPS; g++) begin : g_grp
        logic [GW-1:0] a_g;
        logic [GW-1:0] b_g;
        logic [GW:0]   raw;

        assign a_g = a[g*GW +: GW];
        assign b_g = b[g*GW +: GW];
        assign raw = {1'b0, a_g} + {1'b0, b_g};

        // Carry-in 1 only changes the carry-out when the cin=0 sum is all ones,
        // so gp is exactly "sum is all ones" and sum_p1 is sum + 1 truncated.
        assign grp_d[g].sum    = raw[GW-1:0];
        assign grp_d[g].sum_p1 = raw[GW-1:0] + GW'(1);
        assign grp_d[g].gg     = raw[GW];
        assign grp_d[g].gp     = &raw[GW-1:0];
    end

    // Stage-1 register: loads a new beat (or a bubble) whenever stage 1 may advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            // NOTE: these data registers are flops, not a RAM, so clearing them
            // in reset costs nothing and keeps every stage register defined.
            for (int g = 0; g < N_CLA_GROUPS; g++) begin
                grp_q[g] <= '0;
            end
        end else if (s1_adv) begin
            // NOTE: sequential state uses non-blocking assignment so every flop
            // samples pre-edge values regardless of statement order.
            s1_valid_q <= in_valid;
            if (in_valid) begin
                grp_q <= grp_d;
            end
        end
    end

    // Stage 2: end-around carry resolution
    logic [N_CLA_GROUPS-1:0] gg_vec;
    logic [N_CLA_GROUPS-1:0] gp_vec;
    logic [N_CLA_GROUPS-1:0] carry;

    always_comb begin : flag_gather
        gg_vec = '0;
        gp_vec = '0;
        for (int g = 0; g < N_CLA_GROUPS; g++) begin
            gg_vec[g] = grp_q[g].gg;
            gp_vec[g] = grp_q[g].gp;
        end
    end

    eac_carry_chain #(
        .N_GROUPS (N_CLA_GROUPS)
    ) u_carry_chain (
        .gg_i (gg_vec),
        .gp_i (gp_vec),
        .c_o  (carry)
    );

    logic [ADDER_WIDTH-1:0] res;
    logic [ADDER_WIDTH-1:0] sum_d;
    logic                   is_zero_d;
    logic                   sign_d;

    // Per-group select of sum or sum+1, then zero detection on the final value.
    always_comb begin : result_select
        res = '0;
        for (int g = 0; g < N_CLA_GROUPS; g++) begin
            res[g*GW +: GW] = carry[g] ? grp_q[g].sum_p1 : grp_q[g].sum;
        end
`ifdef EAC_NEG_ZERO_FIX_EN
        // -0 is folded onto +0 so downstream only ever sees one zero encoding.
        sum_d     = (&res) ? '0 : res;
        is_zero_d = (res == '0) || (&res);
`else
        sum_d     = res;
        is_zero_d = (res == '0) || (&res);
`endif
        sign_d = sum_d[ADDER_WIDTH-1];
    end

    logic [ADDER_WIDTH-1:0] sum_q;
    logic                   sign_q;
    logic                   is_zero_q;

    // Output register: holds its beat while downstream stalls, else takes stage 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            sign_q      <= 1'b0;
            is_zero_q   <= 1'b0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                sum_q     <= sum_d;
                sign_q    <= sign_d;
                is_zero_q <= is_zero_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign sign      = sign_q;
    assign is_zero   = is_zero_q;

endmodule
